// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the iterative signed multiply/divide unit.
//   MD_WIDTH   - default operand/result width in bits
//   MD_STEPS   - default iterations per operation (one per operand bit)
//   MD_CNT_W   - width of the step counter
//   md_state_t - controller state encoding (IDLE/MULT/DIV/DONE)
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_STEPS = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/multdiv_counter.sv
// multdiv_counter: 6-bit step counter for the multiply/divide iterations.
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset, clears the count
//   clear    - synchronous clear (new operation), wins over enable
//   enable   - advance the count by one
//   tc       - high while the count equals TERMINAL (the final step is executing)
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter logic [MD_CNT_W-1:0] TERMINAL = 6'd31
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [MD_CNT_W-1:0] count_r;

  // Step count register: reset and clear both return to zero, clear beats enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 6'd0;
    end else if (clear) begin
      count_r <= 6'd0;
    end else if (enable) begin
      count_r <= count_r + 6'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TERMINAL);

endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed multiplier (radix-2 Booth) and divider (non-restoring,
// on magnitudes, quotient truncated toward zero). One step per clock.
//   clock          - rising-edge system clock
//   reset          - synchronous active-high reset
//   data_operandA  - signed multiplicand / dividend (sampled on a start pulse)
//   data_operandB  - signed multiplier / divisor   (sampled on a start pulse)
//   ctrl_MULT      - single-cycle multiply start pulse
//   ctrl_DIV       - single-cycle divide start pulse
//   data_result    - low WIDTH bits of the product, or the quotient
//   data_exception - multiply overflow, divide by zero, or MIN/-1
//   data_resultRDY - one-cycle pulse when data_result/data_exception update
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int STEPS = MD_STEPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement magnitude; MIN maps to 2^(WIDTH-1) read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1]) begin
      m = ~v + ONE_W;
    end else begin
      m = v;
    end
    return m;
  endfunction

  md_state_t state_r, state_next_s;

  logic start_mult_s, start_div_s, div_zero_s;
  logic step_s, last_step_s, cnt_clr_s, tc_s;

  // Shared working register.
  //   multiply: {accumulator[WIDTH-1:0], multiplier[WIDTH-1:0], booth_bit}
  //   divide:   {remainder[WIDTH:0] (signed), quotient/dividend[WIDTH-1:0]}
  logic [2*WIDTH:0] acc_r, acc_next_s;
  logic [WIDTH-1:0] m_r;        // multiplicand or divisor magnitude
  logic             neg_r;      // quotient must be negated
  logic             dov_r;      // divide overflow (MIN / -1)

  // Single WIDTH+1-bit adder/subtractor used by both datapaths.
  logic [WIDTH:0] add_a_s, add_b_s, sum_s;
  logic           add_sub_s;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, mult_res_s, div_res_s;
  logic               mult_exc_s;

  // A cycle with both start pulses high is not a start of either kind.
  assign start_mult_s = ctrl_MULT & ~ctrl_DIV;
  assign start_div_s  = ctrl_DIV & ~ctrl_MULT;
  assign div_zero_s   = (data_operandB == ZERO_W);

  multdiv_counter #(
    .TERMINAL(6'(STEPS - 1))
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr_s),
    .enable(step_s),
    .tc    (tc_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a valid start aborts anything in progress; both pulses high freezes.
  always_comb begin
    state_next_s = state_r;
    if (start_mult_s) begin
      state_next_s = ST_MULT;
    end else if (start_div_s) begin
      state_next_s = div_zero_s ? ST_DONE : ST_DIV;
    end else if (ctrl_MULT & ctrl_DIV) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_IDLE;
        ST_MULT: state_next_s = tc_s ? ST_DONE : ST_MULT;
        ST_DIV:  state_next_s = tc_s ? ST_DONE : ST_DIV;
        ST_DONE: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Controller outputs: iterate only when busy and no start/freeze pulse is present.
  always_comb begin
    step_s = 1'b0;
    case (state_r)
      ST_MULT, ST_DIV:  step_s = ~(ctrl_MULT | ctrl_DIV);
      ST_IDLE, ST_DONE: step_s = 1'b0;
      default:          step_s = 1'b0;
    endcase
  end

  assign last_step_s = step_s & tc_s;
  assign cnt_clr_s   = start_mult_s | start_div_s;

  // Adder operand selection for the current step.
  always_comb begin
    add_a_s   = {(WIDTH+1){1'b0}};
    add_b_s   = {(WIDTH+1){1'b0}};
    add_sub_s = 1'b0;
    case (state_r)
      ST_MULT: begin
        // Sign-extended accumulator so subtracting MIN cannot overflow.
        add_a_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]};
        case (acc_r[1:0])
          2'b01: begin
            add_b_s   = {m_r[WIDTH-1], m_r};
            add_sub_s = 1'b0;
          end
          2'b10: begin
            add_b_s   = {m_r[WIDTH-1], m_r};
            add_sub_s = 1'b1;
          end
          default: begin
            add_b_s   = {(WIDTH+1){1'b0}};
            add_sub_s = 1'b0;
          end
        endcase
      end
      ST_DIV: begin
        // Shift remainder left, pulling in the next dividend bit. Dropping the
        // remainder's top bit is safe: |remainder| < divisor <= 2^(WIDTH-1).
        add_a_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        add_b_s   = {1'b0, m_r};
        add_sub_s = ~acc_r[2*WIDTH];
      end
      ST_IDLE, ST_DONE: begin
        add_a_s   = {(WIDTH+1){1'b0}};
        add_b_s   = {(WIDTH+1){1'b0}};
        add_sub_s = 1'b0;
      end
      default: begin
        add_a_s   = {(WIDTH+1){1'b0}};
        add_b_s   = {(WIDTH+1){1'b0}};
        add_sub_s = 1'b0;
      end
    endcase
  end

  assign sum_s = add_a_s + (add_b_s ^ {(WIDTH+1){add_sub_s}}) + {{WIDTH{1'b0}}, add_sub_s};

  // Next working-register value after one step.
  always_comb begin
    acc_next_s = acc_r;
    case (state_r)
      // Arithmetic shift right of {sum, multiplier, booth_bit}; sum's extra bit is kept.
      ST_MULT: acc_next_s = {sum_s, acc_r[WIDTH:1]};
      // New remainder on top, quotient bit = remainder non-negative.
      ST_DIV:  acc_next_s = {sum_s, acc_r[WIDTH-2:0], ~sum_s[WIDTH]};
      ST_IDLE, ST_DONE: acc_next_s = acc_r;
      default: acc_next_s = acc_r;
    endcase
  end

  assign prod_s     = acc_next_s[2*WIDTH:1];
  assign mult_res_s = prod_s[WIDTH-1:0];
  assign mult_exc_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
  assign quot_s     = acc_next_s[WIDTH-1:0];
  assign div_res_s  = neg_r ? (~quot_s + ONE_W) : quot_s;

  // Datapath registers: load operands on start, advance one step when iterating.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r <= {(2*WIDTH+1){1'b0}};
      m_r   <= ZERO_W;
      neg_r <= 1'b0;
      dov_r <= 1'b0;
    end else if (start_mult_s) begin
      acc_r <= {ZERO_W, data_operandB, 1'b0};
      m_r   <= data_operandA;
      neg_r <= 1'b0;
      dov_r <= 1'b0;
    end else if (start_div_s) begin
      acc_r <= {1'b0, ZERO_W, magnitude(data_operandA)};
      m_r   <= magnitude(data_operandB);
      neg_r <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dov_r <= (data_operandA == MIN_W) && (data_operandB == ONES_W);
    end else if (step_s) begin
      acc_r <= acc_next_s;
      m_r   <= m_r;
      neg_r <= neg_r;
      dov_r <= dov_r;
    end else begin
      acc_r <= acc_r;
      m_r   <= m_r;
      neg_r <= neg_r;
      dov_r <= dov_r;
    end
  end

  // Result registers: updated together with the single-cycle ready pulse, held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= ZERO_W;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (start_div_s && div_zero_s) begin
      data_result    <= ZERO_W;
      data_exception <= 1'b1;
      data_resultRDY <= 1'b1;
    end else if (last_step_s) begin
      if (state_r == ST_MULT) begin
        data_result    <= mult_res_s;
        data_exception <= mult_exc_s;
      end else begin
        data_result    <= div_res_s;
        data_exception <= dov_r;
      end
      data_resultRDY <= 1'b1;
    end else begin
      data_result    <= data_result;
      data_exception <= data_exception;
      data_resultRDY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed, table-driven self-checking bench for multdiv, plus
// hand-written sequences for abort, reset-during-operation and dual-start cases.
module tb_multdiv;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks   = 0;
  int failures = 0;

  multdiv #(.WIDTH(32), .STEPS(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Start one operation and wait (bounded) for its ready pulse.
  // lat is the number of clock edges from the start edge to the visible RDY.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = ~is_div;
    ctrl_DIV      = is_div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    // Operands must have been captured; scramble them (including a zero divisor).
    data_operandA = ~a;
    data_operandB = 32'h0000_0000;
    lat = 1;
    while (!data_resultRDY && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    res = data_result;
    exc = data_exception;
  endtask

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] res;
    logic        exc;
    int          n_rdy;
    int          rdy_cyc;
    logic [31:0] rdy_res;
    logic        rdy_exc;

    vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1, 1};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
    vecs[5]  = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1, 33};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'h0000_001E, 1'b0, 33};
    vecs[7]  = '{1'b1, 32'd100,        32'd7,         32'd14,        1'b0, 33};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0, 33};
    vecs[10] = '{1'b0, 32'h4000_0000,  32'd2,         32'h8000_0000, 1'b1, 33};
    vecs[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0, 33};
    vecs[12] = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33};
    vecs[13] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
    vecs[14] = '{1'b1, 32'd0,          32'd5,         32'h0000_0000, 1'b0, 33};
    vecs[15] = '{1'b1, 32'h7FFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[16] = '{1'b1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0, 33};

    reset         = 1'b1;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;

    // Reset state, with a start pulse present to show reset wins.
    @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd0;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    check("reset_result", data_result, 32'h0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, lat, res, exc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_exception", i), {31'd0, exc}, {31'd0, vecs[i].exc});
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_rdy_pulse_width", i), {31'd0, data_resultRDY}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), data_result, vecs[i].res);
    end

    // Abort: multiply 9*9 at N, divide 100/7 at N+10 -> one RDY at N+43, result 14.
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    n_rdy   = 0;
    rdy_cyc = 0;
    rdy_res = 32'h0;
    rdy_exc = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        n_rdy++;
        rdy_cyc = c;
        rdy_res = data_result;
        rdy_exc = data_exception;
      end
      if (c == 1) ctrl_MULT = 1'b0;
      if (c == 10) begin
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV      = 1'b1;
      end
      if (c == 11) ctrl_DIV = 1'b0;
    end
    check("abort_rdy_count", 32'(n_rdy), 32'd1);
    check("abort_rdy_cycle", 32'(rdy_cyc), 32'd43);
    check("abort_result", rdy_res, 32'd14);
    check("abort_exception", {31'd0, rdy_exc}, 32'd0);

    // Reset at N+20 of a divide: outputs clear next cycle, no RDY afterwards.
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    n_rdy = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) n_rdy++;
      if (c == 1) ctrl_DIV = 1'b0;
      if (c == 20) begin
        check("midop_result_held", data_result, 32'd14);
        reset = 1'b1;
      end
      if (c == 21) begin
        reset = 1'b0;
        check("midreset_result", data_result, 32'h0);
        check("midreset_exception", {31'd0, data_exception}, 32'd0);
      end
    end
    check("midreset_no_rdy", 32'(n_rdy), 32'd0);

    // Both start pulses together in IDLE: ignored, outputs untouched.
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, res, exc);
    check("pre_dual_result", res, 32'hFFFF_FFEB);
    @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd0;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    n_rdy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) n_rdy++;
      if (c == 1) begin
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
      end
    end
    check("dual_no_rdy", 32'(n_rdy), 32'd0);
    check("dual_result", data_result, 32'hFFFF_FFEB);
    check("dual_exception", {31'd0, data_exception}, 32'd0);

    // Unit still operational afterwards.
    run_op(1'b1, 32'd5, 32'd0, lat, res, exc);
    check("post_dual_latency", 32'(lat), 32'd1);
    check("post_dual_exception", {31'd0, exc}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL provide parameter STEPS, default 32, iteration count per operation; equal to WIDTH.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clock, input, 1, rising-edge system clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_operandA, input, WIDTH, signed two's-complement multiplicand or dividend.
REQ-007 SHALL have port data_operandB, input, WIDTH, signed two's-complement multiplier or divisor.
REQ-008 SHALL have port ctrl_MULT, input, 1, single-cycle multiply start pulse.
REQ-009 SHALL have port ctrl_DIV, input, 1, single-cycle divide start pulse.
REQ-010 SHALL have port data_result, output, WIDTH, product (low WIDTH bits) or quotient.
REQ-011 SHALL have port data_exception, output, 1, overflow or divide error flag for current result.
REQ-012 SHALL have port data_resultRDY, output, 1, single-cycle result-valid pulse.

Function
REQ-013 SHALL use states IDLE, MULT, DIV and DONE.
REQ-014 SHALL sample both operands only in the cycle in which a start pulse is high.
REQ-015 SHALL move from IDLE, MULT, DIV or DONE to MULT on ctrl_MULT=1, ctrl_DIV=0.
REQ-016 SHALL move from IDLE, MULT, DIV or DONE to DIV on ctrl_DIV=1, ctrl_MULT=0.
REQ-017 SHALL ignore a cycle with ctrl_MULT=1 and ctrl_DIV=1: no state change and no outputs touched.
REQ-018 SHALL abort an operation in progress on a new start pulse, with no RDY for the aborted operation; the new operation restarts from step 0.
REQ-019 SHALL compute multiply by radix-2 Booth: one add/sub/nop plus arithmetic right shift per cycle over a 2*WIDTH+1-bit product register.
REQ-020 SHALL compute divide by non-restoring division on operand magnitudes: one quotient bit per cycle, then sign correction.
REQ-021 SHALL truncate the signed quotient toward zero and discard the remainder.
REQ-022 SHALL count steps with a counter that clears on start and ends the operation at STEPS.
REQ-023 SHALL pulse data_resultRDY exactly STEPS+1 cycles after the start cycle (start in cycle N, RDY in cycle N+33), then go MULT/DIV -> DONE -> IDLE.
REQ-024 SHALL set data_exception=1 on multiply when the full 2*WIDTH product differs from the sign-extension of its low WIDTH bits; data_result still carries the low WIDTH bits.
REQ-025 SHALL handle divisor 0 by pulsing RDY at N+1 with data_result=0 and data_exception=1, without iterating.
REQ-026 SHALL handle dividend -2^(WIDTH-1) with divisor -1 by returning 0x80000000 with data_exception=1, RDY at N+33.
REQ-027 SHALL hold data_result and data_exception stable from the RDY cycle until the next RDY or reset.
REQ-028 SHALL keep data_resultRDY low in every cycle except the completion cycle.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, force state IDLE, counter 0, data_result 0, data_exception 0 and data_resultRDY 0.
REQ-030 SHALL abandon an operation in progress when reset occurs and never produce its RDY.
REQ-031 SHALL give reset priority over simultaneous start pulses.

Structure
REQ-032 SHALL keep state encodings (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3) and STEPS in the shared cpu defines include.
REQ-033 SHALL place the step counter in one sub-module, multdiv_counter: 6-bit, synchronous clear, enable, terminal-count output.
REQ-034 SHALL share one WIDTH+1-bit adder/subtractor between the multiply and divide datapaths.

Verification
REQ-035 SHALL check: ctrl_MULT with A=7, B=-3 -> RDY at N+33, result 0xFFFFFFEB, exception 0.
REQ-036 SHALL check: ctrl_MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1.
REQ-037 SHALL check: ctrl_DIV with A=-7, B=2 -> RDY at N+33, result 0xFFFFFFFD, exception 0; and A=5, B=0 -> RDY at N+1, result 0, exception 1.
REQ-038 SHALL check: ctrl_MULT (9*9) then ctrl_DIV with A=100, B=7 at N+10 -> exactly one RDY, at N+43, result 14.
REQ-039 SHALL check: reset at N+20 of a divide -> outputs 0 next cycle, no RDY through N+40.
REQ-040 SHALL check: ctrl_MULT and ctrl_DIV high together in IDLE -> no RDY within 40 cycles, outputs unchanged.
